acc_cpu_core: RTL

//  Parametrised successor of the 8-bit accumulator CPU: a multi-cycle accumulator core with a

---
 rtl/acc_cpu_pkg.sv | 25 ++
 rtl/acc_cpu_core_alu.sv | 26 ++
 rtl/acc_cpu_core.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/acc_cpu_pkg.sv
// Shared definitions for the parametrised accumulator CPU: opcodes, FSM states, instruction width.
package acc_cpu_pkg;

  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  typedef enum logic [2:0] {
    S_HALT,
    S_LOAD,
    S_FETCH,
    S_EXEC,
    S_WB
  } state_t;

  function automatic int instr_w(input int addr_w);
    return 3 + addr_w;
  endfunction

endpackage

// File: rtl/acc_cpu_core_alu.sv
// Combinational accumulator ALU: (a, b, op) -> (res, carry); carry is only produced by ADD.
module acc_alu
  import acc_cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        op,
  output logic [DATA_W-1:0] res,
  output logic              carry
);

  always_comb begin
    res   = a;
    carry = 1'b0;
    case (op)
      OP_ADD:  {carry, res} = {1'b0, a} + {1'b0, b};
      OP_AND:  res = a & b;
      OP_XOR:  res = a ^ b;
      OP_LDA:  res = b;
      default: res = a;
    endcase
  end

endmodule

// File: rtl/acc_cpu_core.sv
// Multi-cycle accumulator core (FETCH/EXEC/WB) with internal IMEM/DMEM, word loader,
// halt/resume, single-step mode and carry/zero flags.
module acc_cpu_core
  import acc_cpu_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 5,
  parameter int ACC_RESET = 3,
  localparam int INSTR_W  = instr_w(ADDR_W)
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               Load,
  input  logic               Load_valid,
  input  logic [INSTR_W-1:0] Load_data,
  output logic               Load_ready,
  output logic               Load_ovf,
  input  logic               Start,
  input  logic               Step_mode,
  output logic               Halted,
  output logic [INSTR_W-1:0] Instruction,
  output logic [ADDR_W-1:0]  Program_cnt,
  output logic [DATA_W-1:0]  Acc,
  output logic [DATA_W-1:0]  Mem,
  output logic               Zero,
  output logic               Carry
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [DATA_W-1:0] ACC_INIT = DATA_W'(ACC_RESET);

  state_t              state;
  logic [INSTR_W-1:0]  imem [DEPTH];
  logic [DATA_W-1:0]   dmem [DEPTH];
  logic [INSTR_W-1:0]  ir;
  logic [ADDR_W-1:0]   pc;
  logic [DATA_W-1:0]   acc;
  logic                carry;
  logic [ADDR_W-1:0]   load_ptr;
  logic                load_full;
  logic                load_ovf;
  logic [DATA_W-1:0]   res_p1;
  logic                carry_p1;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_carry;
  logic [2:0]          opcode;
  logic [ADDR_W-1:0]   opaddr;

  assign opcode = ir[INSTR_W-1 -: 3];
  assign opaddr = ir[ADDR_W-1:0];

  acc_alu #(.DATA_W(DATA_W)) u_alu (
    .a     (acc),
    .b     (dmem[opaddr]),
    .op    (opcode),
    .res   (alu_res),
    .carry (alu_carry)
  );

  // IMEM is deliberately left out of reset so a loaded program survives a reset pulse.
  always_ff @(posedge Clk) begin
    if (state == S_LOAD && Load_valid)
      imem[load_ptr] <= Load_data;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= S_HALT;
      pc        <= '0;
      ir        <= '0;
      acc       <= ACC_INIT;
      carry     <= 1'b0;
      load_ptr  <= '0;
      load_full <= 1'b0;
      load_ovf  <= 1'b0;
      res_p1    <= '0;
      carry_p1  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) dmem[i] <= '0;
    end else if (Load && state != S_LOAD) begin
      // Entering load aborts whatever was in flight; no architectural write happens this cycle.
      state     <= S_LOAD;
      load_ptr  <= '0;
      load_full <= 1'b0;
      load_ovf  <= 1'b0;
    end else begin
      case (state)
        S_HALT: if (Start) state <= S_FETCH;
        S_LOAD: begin
          if (Load_valid) begin
            load_ptr <= load_ptr + ADDR_W'(1);
            if (load_ptr == '1) load_full <= 1'b1;
            if (load_full)      load_ovf  <= 1'b1;
          end
          if (!Load) begin
            pc    <= '0;
            ir    <= '0;
            state <= S_HALT;
          end
        end
        // fetch stage
        S_FETCH: begin
          ir    <= imem[pc];
          state <= S_EXEC;
        end
        // execute stage: ALU result registered for write-back
        S_EXEC: begin
          res_p1   <= alu_res;
          carry_p1 <= alu_carry;
          state    <= S_WB;
        end
        // write-back stage
        S_WB: begin
          case (opcode)
            OP_ADD: begin
              acc   <= res_p1;
              carry <= carry_p1;
            end
            OP_AND, OP_XOR, OP_LDA: acc <= res_p1;
            OP_STO: dmem[opaddr] <= acc;
            default: ;
          endcase
          if (opcode == OP_JMP)
            pc <= opaddr;
          else if (opcode == OP_SKZ && acc == '0)
            pc <= pc + ADDR_W'(2);
          else
            pc <= pc + ADDR_W'(1);
          if (opcode == OP_HLT || Step_mode)
            state <= S_HALT;
          else
            state <= S_FETCH;
        end
        default: state <= S_HALT;
      endcase
    end
  end

  assign Load_ready  = (state == S_LOAD);
  assign Load_ovf    = load_ovf;
  assign Halted      = (state == S_HALT);
  assign Instruction = ir;
  assign Program_cnt = pc;
  assign Acc         = acc;
  assign Mem         = dmem[opaddr];
  assign Zero        = (acc == '0);
  assign Carry       = carry;

endmodule
